// File: rtl/imm_encoder.sv
// -----------------------------------------------------------------------------
// imm_encoder
//
// Iterative encoder for ARM data-processing rotated immediates. Given a 32-bit
// constant it searches rot4 = 0..MAX_ROT, one value per clock, for an imm8 such
// that constant == ROR(imm8, 2*rot4). With ALLOW_INV=1 it also looks for an
// encoding of ~constant (MOV->MVN / AND->BIC substitution), which is used only
// when no direct encoding exists.
//
// Parameters
//   ALLOW_INV  1 = also search ~value and report out_inv; 0 = direct only
//   MAX_ROT    highest rot4 tested (0..15)
//
// Ports
//   clk        rising-edge clock
//   reset_n    asynchronous active-low reset
//   in_valid   request valid
//   in_ready   block can accept a request (IDLE only)
//   in_value   constant to encode (sampled on the accepting edge)
//   out_valid  result valid (DONE only)
//   out_ready  consumer accepts result
//   out_imm8   encoded immediate
//   out_rot    rotate field; rotate amount = 2*out_rot
//   out_inv    1 = encoding is for ~in_value
//   out_ok     1 = encodable; 0 = imm8/rot/inv all zero
//   out_field  {out_rot, out_imm8}, the operand2 bits
// -----------------------------------------------------------------------------
module imm_encoder #(
    parameter int ALLOW_INV = 1,
    parameter int MAX_ROT   = 15
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_value,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [7:0]  out_imm8,
    output logic [3:0]  out_rot,
    output logic        out_inv,
    output logic        out_ok,
    output logic [11:0] out_field
);

    localparam logic [3:0] MAX_K = 4'(MAX_ROT);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SEARCH = 2'd1,
        DONE   = 2'd2
    } state_t;

    state_t      state_reg;
    logic [31:0] v_reg;
    logic [3:0]  k_reg;

    // First (smallest-k) inverted hit, kept until the direct search is exhausted.
    logic        inv_found_reg;
    logic [7:0]  inv_imm_reg;
    logic [3:0]  inv_rot_reg;

    // Rotating left by 2k undoes ROR(imm8, 2k); the candidate is valid when
    // everything above the low byte comes back as zero.
    function automatic logic [31:0] rol32(input logic [31:0] x, input logic [4:0] sh);
        rol32 = (x << sh) | (x >> (6'd32 - {1'b0, sh}));
    endfunction

    logic [4:0]  shamt;
    logic [31:0] d;
    logic        direct_hit;
    logic        inv_hit;
    logic [7:0]  inv_byte;
    logic        last_k;

    assign shamt      = {k_reg, 1'b0};
    assign d          = rol32(v_reg, shamt);
    assign direct_hit = (d[31:8] == 24'h0);
    assign last_k     = (k_reg == MAX_K);

    generate
        if (ALLOW_INV != 0) begin : g_inv
            logic [31:0] n;
            assign n        = rol32(~v_reg, shamt);
            assign inv_hit  = (n[31:8] == 24'h0);
            assign inv_byte = n[7:0];
        end else begin : g_noinv
            assign inv_hit  = 1'b0;
            assign inv_byte = 8'h00;
        end
    endgenerate

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg     <= IDLE;
            v_reg         <= 32'h0;
            k_reg         <= 4'h0;
            inv_found_reg <= 1'b0;
            inv_imm_reg   <= 8'h0;
            inv_rot_reg   <= 4'h0;
            out_imm8      <= 8'h0;
            out_rot       <= 4'h0;
            out_inv       <= 1'b0;
            out_ok        <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (in_valid) begin
                        v_reg         <= in_value;
                        k_reg         <= 4'h0;
                        inv_found_reg <= 1'b0;
                        state_reg     <= SEARCH;
                    end
                end

                SEARCH: begin
                    if (direct_hit) begin
                        // Smallest direct rotation wins outright.
                        out_imm8  <= d[7:0];
                        out_rot   <= k_reg;
                        out_inv   <= 1'b0;
                        out_ok    <= 1'b1;
                        state_reg <= DONE;
                    end else begin
                        if (inv_hit && !inv_found_reg) begin
                            inv_found_reg <= 1'b1;
                            inv_imm_reg   <= inv_byte;
                            inv_rot_reg   <= k_reg;
                        end
                        if (last_k) begin
                            // The inverted hit may be at this very k, so the
                            // live result is used when nothing was stored yet.
                            state_reg <= DONE;
                            if (inv_found_reg) begin
                                out_imm8 <= inv_imm_reg;
                                out_rot  <= inv_rot_reg;
                                out_inv  <= 1'b1;
                                out_ok   <= 1'b1;
                            end else if (inv_hit) begin
                                out_imm8 <= inv_byte;
                                out_rot  <= k_reg;
                                out_inv  <= 1'b1;
                                out_ok   <= 1'b1;
                            end else begin
                                out_imm8 <= 8'h0;
                                out_rot  <= 4'h0;
                                out_inv  <= 1'b0;
                                out_ok   <= 1'b0;
                            end
                        end else begin
                            k_reg <= k_reg + 4'h1;
                        end
                    end
                end

                DONE: begin
                    if (out_ready) begin
                        state_reg <= IDLE;
                    end
                end

                default: state_reg <= IDLE;
            endcase
        end
    end

    assign in_ready  = (state_reg == IDLE);
    assign out_valid = (state_reg == DONE);
    assign out_field = {out_rot, out_imm8};

endmodule

// File: tb/tb_imm_encoder.sv
// -----------------------------------------------------------------------------
// tb_imm_encoder
//
// Two encoders share one request stream: dut (ALLOW_INV=1) and dut_ni
// (ALLOW_INV=0). A directed vector table, hand-written reset / backpressure
// sequences and randomized constants are checked against a brute-force model
// that enumerates every (imm8, rot) pair.
// -----------------------------------------------------------------------------
module tb_imm_encoder;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        in_valid;
    logic [31:0] in_value;
    logic        out_ready;

    logic        a_in_ready, a_out_valid, a_out_inv, a_out_ok;
    logic [7:0]  a_out_imm8;
    logic [3:0]  a_out_rot;
    logic [11:0] a_out_field;
    logic        b_in_ready, b_out_valid, b_out_inv, b_out_ok;
    logic [7:0]  b_out_imm8;
    logic [3:0]  b_out_rot;
    logic [11:0] b_out_field;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    imm_encoder #(.ALLOW_INV(1), .MAX_ROT(15)) dut (
        .clk(clk), .reset_n(reset_n),
        .in_valid(in_valid), .in_ready(a_in_ready), .in_value(in_value),
        .out_valid(a_out_valid), .out_ready(out_ready),
        .out_imm8(a_out_imm8), .out_rot(a_out_rot), .out_inv(a_out_inv),
        .out_ok(a_out_ok), .out_field(a_out_field)
    );

    imm_encoder #(.ALLOW_INV(0), .MAX_ROT(15)) dut_ni (
        .clk(clk), .reset_n(reset_n),
        .in_valid(in_valid), .in_ready(b_in_ready), .in_value(in_value),
        .out_valid(b_out_valid), .out_ready(out_ready),
        .out_imm8(b_out_imm8), .out_rot(b_out_rot), .out_inv(b_out_inv),
        .out_ok(b_out_ok), .out_field(b_out_field)
    );

    // Captured results, index 0 = dut, 1 = dut_ni.
    logic        cap_ok[2], cap_inv[2];
    logic [7:0]  cap_imm[2];
    logic [3:0]  cap_rot[2];
    logic [11:0] cap_field[2];
    int          cap_lat[2];

    typedef struct {
        logic [31:0] val;
        logic [7:0]  imm;
        logic [3:0]  rot;
        logic        inv;
        logic        ok;
        int          lat;
    } vec_t;

    function automatic logic [31:0] ror32(input logic [31:0] x, input int r);
        logic [63:0] t;
        t = {x, x} >> r;
        return t[31:0];
    endfunction

    // Brute force: smallest rot whose ROR(imm8, 2*rot) reproduces the value;
    // inverted form considered only when no direct form exists.
    task automatic model(input logic [31:0] v, input bit allow,
                         output logic ok, output logic inv, output logic [7:0] imm,
                         output logic [3:0] rot, output int lat);
        ok = 0; inv = 0; imm = 0; rot = 0; lat = 16;
        for (int k = 0; k < 16 && !ok; k++)
            for (int i = 0; i < 256; i++)
                if (!ok && ror32(32'(i), 2 * k) == v) begin
                    ok = 1; imm = 8'(i); rot = 4'(k); lat = k + 1;
                end
        if (!ok && allow)
            for (int k = 0; k < 16 && !ok; k++)
                for (int i = 0; i < 256; i++)
                    if (!ok && ror32(32'(i), 2 * k) == ~v) begin
                        ok = 1; inv = 1; imm = 8'(i); rot = 4'(k);
                    end
    endtask

    task automatic check(input string name, input logic cond, input string detail);
        checks++;
        if (!cond) begin
            failures++;
            $display("FAIL %s %s", name, detail);
        end
    endtask

    task automatic check_res(input string name, input int inst, input logic [31:0] v,
                             input logic eok, input logic einv, input logic [7:0] eimm,
                             input logic [3:0] erot, input int elat);
        logic [11:0] efield;
        logic        good;
        efield = {erot, eimm};
        good = (cap_ok[inst] === eok) && (cap_inv[inst] === einv) &&
               (cap_imm[inst] === eimm) && (cap_rot[inst] === erot) &&
               (cap_field[inst] === efield) && (cap_lat[inst] == elat);
        checks++;
        if (!good) begin
            failures++;
            $display("FAIL %s inst%0d val=%h got ok=%0d inv=%0d imm=%h rot=%0d field=%h lat=%0d required ok=%0d inv=%0d imm=%h rot=%0d field=%h lat=%0d",
                     name, inst, v, cap_ok[inst], cap_inv[inst], cap_imm[inst], cap_rot[inst],
                     cap_field[inst], cap_lat[inst], eok, einv, eimm, erot, efield, elat);
        end else begin
            $display("txn %s inst%0d val=%h ok=%0d inv=%0d imm=%h rot=%0d lat=%0d",
                     name, inst, v, eok, einv, eimm, erot, elat);
        end
    endtask

    // Issue one request to both encoders, collect both results, then release.
    task automatic do_req(input logic [31:0] v);
        int  cyc;
        bit  got0, got1;
        cyc = 0;
        while (!(a_in_ready && b_in_ready) && cyc < 50) begin
            @(posedge clk); #1; cyc++;
        end
        if (!(a_in_ready && b_in_ready)) begin
            checks++; failures++;
            $display("FAIL ready_timeout val=%h got in_ready=%0d/%0d required 1/1", v, a_in_ready, b_in_ready);
        end
        in_valid = 1'b1;
        in_value = v;
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_value = $urandom;          // must be ignored while searching
        cyc = 0; got0 = 0; got1 = 0;
        cap_lat[0] = -1; cap_lat[1] = -1;
        while (!(got0 && got1) && cyc < 40) begin
            @(posedge clk); #1; cyc++;
            if (a_out_valid && !got0) begin
                got0 = 1; cap_lat[0] = cyc; cap_ok[0] = a_out_ok; cap_inv[0] = a_out_inv;
                cap_imm[0] = a_out_imm8; cap_rot[0] = a_out_rot; cap_field[0] = a_out_field;
            end
            if (b_out_valid && !got1) begin
                got1 = 1; cap_lat[1] = cyc; cap_ok[1] = b_out_ok; cap_inv[1] = b_out_inv;
                cap_imm[1] = b_out_imm8; cap_rot[1] = b_out_rot; cap_field[1] = b_out_field;
            end
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic run_and_model(input string name, input logic [31:0] v);
        logic ok, inv; logic [7:0] imm; logic [3:0] rot; int lat;
        do_req(v);
        model(v, 1'b1, ok, inv, imm, rot, lat);
        check_res(name, 0, v, ok, inv, imm, rot, lat);
        model(v, 1'b0, ok, inv, imm, rot, lat);
        check_res(name, 1, v, ok, inv, imm, rot, lat);
    endtask

    vec_t vecs[9];

    initial begin
        vecs[0] = '{32'h000000FF, 8'hFF, 4'd0,  1'b0, 1'b1, 1};
        vecs[1] = '{32'hFF000000, 8'hFF, 4'd4,  1'b0, 1'b1, 5};
        vecs[2] = '{32'hF000000F, 8'hFF, 4'd2,  1'b0, 1'b1, 3};
        vecs[3] = '{32'h000003FC, 8'hFF, 4'd15, 1'b0, 1'b1, 16};
        vecs[4] = '{32'hFFFFFF00, 8'hFF, 4'd0,  1'b1, 1'b1, 16};
        vecs[5] = '{32'h00000101, 8'h00, 4'd0,  1'b0, 1'b0, 16};
        vecs[6] = '{32'h00000000, 8'h00, 4'd0,  1'b0, 1'b1, 1};
        vecs[7] = '{32'hFFFFFFFF, 8'h00, 4'd0,  1'b1, 1'b1, 16};
        vecs[8] = '{32'h3F000000, 8'h3F, 4'd4,  1'b0, 1'b1, 5};

        reset_n = 1'b0; in_valid = 1'b0; in_value = 32'h0; out_ready = 1'b0;
        @(posedge clk); @(posedge clk); #1;
        check("reset_state", {a_in_ready, a_out_valid, a_out_ok, a_out_inv, a_out_field} == {1'b1, 1'b0, 1'b0, 1'b0, 12'h0} &&
                             {b_in_ready, b_out_valid, b_out_ok, b_out_field} == {1'b1, 1'b0, 1'b0, 12'h0},
              $sformatf("got rdy=%0d vld=%0d ok=%0d inv=%0d field=%h required rdy=1 vld=0 ok=0 inv=0 field=000",
                        a_in_ready, a_out_valid, a_out_ok, a_out_inv, a_out_field));
        reset_n = 1'b1;
        @(posedge clk); #1;

        // Directed table: inst0 against the table, inst1 (no inversion) against the model.
        for (int i = 0; i < 9; i++) begin
            logic ok, inv; logic [7:0] imm; logic [3:0] rot; int lat;
            do_req(vecs[i].val);
            check_res($sformatf("vec%0d", i), 0, vecs[i].val, vecs[i].ok, vecs[i].inv,
                      vecs[i].imm, vecs[i].rot, vecs[i].lat);
            model(vecs[i].val, 1'b0, ok, inv, imm, rot, lat);
            check_res($sformatf("vec%0d", i), 1, vecs[i].val, ok, inv, imm, rot, lat);
        end
        // The no-inversion case of 0xFFFFFF00 must be unencodable.
        do_req(32'hFFFFFF00);
        check_res("noinv_ff00", 1, 32'hFFFFFF00, 1'b0, 1'b0, 8'h00, 4'd0, 16);

        // Reset in the middle of a search abandons the request.
        in_valid = 1'b1; in_value = 32'h00000101;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (4) begin @(posedge clk); #1; end
        reset_n = 1'b0;
        #1;
        check("reset_mid", a_out_valid == 1'b0 && a_in_ready == 1'b1 && b_out_valid == 1'b0 && b_in_ready == 1'b1,
              $sformatf("got vld=%0d rdy=%0d required vld=0 rdy=1", a_out_valid, a_in_ready));
        @(posedge clk); #1;
        check("reset_hold", a_out_valid == 1'b0 && a_out_ok == 1'b0,
              $sformatf("got vld=%0d ok=%0d required 0 0", a_out_valid, a_out_ok));
        reset_n = 1'b1;
        do_req(32'h000000FF);
        check_res("after_reset", 0, 32'hFF, 1'b1, 1'b0, 8'hFF, 4'd0, 1);

        // Backpressure: result held, second request ignored until release.
        in_valid = 1'b1; in_value = 32'h3F000000;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (5) begin @(posedge clk); #1; end
        check("bp_first", a_out_valid && a_out_field == 12'h43F && a_out_ok && !a_out_inv,
              $sformatf("got vld=%0d field=%h required vld=1 field=43f", a_out_valid, a_out_field));
        for (int c = 0; c < 10; c++) begin
            if (c == 3) begin in_valid = 1'b1; in_value = 32'h000000FF; end
            @(posedge clk); #1;
            check($sformatf("bp_hold%0d", c),
                  a_out_valid && !a_in_ready && a_out_field == 12'h43F && a_out_ok && !a_out_inv,
                  $sformatf("got vld=%0d rdy=%0d field=%h required vld=1 rdy=0 field=43f",
                            a_out_valid, a_in_ready, a_out_field));
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check("bp_release", !a_out_valid && a_in_ready,
              $sformatf("got vld=%0d rdy=%0d required vld=0 rdy=1", a_out_valid, a_in_ready));
        @(posedge clk); #1;
        in_valid = 1'b0;
        check("bp_accept", !a_in_ready && !a_out_valid,
              $sformatf("got rdy=%0d vld=%0d required rdy=0 vld=0", a_in_ready, a_out_valid));
        @(posedge clk); #1;
        check("bp_second", a_out_valid && a_out_field == 12'h0FF && a_out_ok,
              $sformatf("got vld=%0d field=%h required vld=1 field=0ff", a_out_valid, a_out_field));
        out_ready = 1'b1;
        repeat (20) begin @(posedge clk); #1; end   // let dut_ni (same result) drain too
        out_ready = 1'b0;

        // Randomized constants, biased toward encodable and inverted forms.
        for (int t = 0; t < 150; t++) begin
            logic [31:0] v;
            case ($urandom_range(0, 3))
                0: v = $urandom;
                1: v = ror32(32'($urandom_range(0, 255)), 2 * $urandom_range(0, 15));
                2: v = ~ror32(32'($urandom_range(0, 255)), 2 * $urandom_range(0, 15));
                default: v = $urandom & (32'h000000FF << $urandom_range(0, 24));
            endcase
            run_and_model($sformatf("rnd%0d", t), v);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
